fetch: RTL and testbench

FETCH -- requirements
Module: fetch

---
 rtl/fetch.sv | 84 ++++++++
 tb/tb_fetch.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/fetch.sv
// Instruction-fetch program counter: N-bit PC that advances by 4 or loads a branch target every cycle.
// The adder, next-PC mux and PC register are separate parameterised sub-blocks.

module fetch_adder #(
  parameter int N = 64
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic [N-1:0] sum_o
);
  // Carry-out is dropped so the sum wraps modulo 2^N.
  assign sum_o = a_i + b_i;
endmodule

module fetch_mux2 #(
  parameter int N = 64
) (
  input  logic         sel_i,
  input  logic [N-1:0] d0_i,
  input  logic [N-1:0] d1_i,
  output logic [N-1:0] y_o
);
  assign y_o = sel_i ? d1_i : d0_i;
endmodule

module fetch_pc_reg #(
  parameter int N = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] d_i,
  output logic [N-1:0] q_o
);
  logic [N-1:0] pc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= '0;
    end else begin
      pc_q <= d_i;
    end
  end

  assign q_o = pc_q;
endmodule

module fetch #(
  parameter int N = 64
) (
  input  logic         PCSrc_F,
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] PCBranch_F,
  output logic [N-1:0] imem_addr_F
);
  localparam logic [N-1:0] PcStep = N'(4);

  logic [N-1:0] pc_q;
  logic [N-1:0] pc_plus4;
  logic [N-1:0] pc_d;

  fetch_adder #(.N(N)) u_adder (
    .a_i   (pc_q),
    .b_i   (PcStep),
    .sum_o (pc_plus4)
  );

  fetch_mux2 #(.N(N)) u_mux (
    .sel_i (PCSrc_F),
    .d0_i  (pc_plus4),
    .d1_i  (PCBranch_F),
    .y_o   (pc_d)
  );

  // Branch targets are loaded as-is; no alignment masking.
  fetch_pc_reg #(.N(N)) u_pc_reg (
    .clk   (clk),
    .rst_n (reset),
    .d_i   (pc_d),
    .q_o   (pc_q)
  );

  assign imem_addr_F = pc_q;
endmodule

// File: tb/tb_fetch.sv
// Directed self-checking bench for the fetch PC: reset, sequential advance, branches, wrap and unaligned targets.

module tb_fetch;
  localparam int N = 64;

  logic         clk;
  logic         reset;
  logic         PCSrc_F;
  logic [N-1:0] PCBranch_F;
  logic [N-1:0] imem_addr_F;

  int total_cnt;
  int bad_cnt;

  fetch #(.N(N)) dut (
    .PCSrc_F     (PCSrc_F),
    .clk         (clk),
    .reset       (reset),
    .PCBranch_F  (PCBranch_F),
    .imem_addr_F (imem_addr_F)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    total_cnt++;
    if (obs !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%016h", tag, obs);
    end
  endtask

  // Advance one rising edge and land 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total_cnt  = 0;
    bad_cnt    = 0;
    reset      = 1'b1;
    PCSrc_F    = 1'b0;
    PCBranch_F = '0;
    #2;

    // Reset takes effect immediately, then holds across two edges.
    reset = 1'b0;
    #1;
    check("reset_async", imem_addr_F, 64'h0);
    step();
    check("reset_edge1", imem_addr_F, 64'h0);
    step();
    check("reset_edge2", imem_addr_F, 64'h0);

    // Release between edges: no change until the next rising edge.
    #2;
    reset = 1'b1;
    #1;
    check("release_hold", imem_addr_F, 64'h0);
    step();
    check("seq_4", imem_addr_F, 64'h4);
    step();
    check("seq_8", imem_addr_F, 64'h8);
    step();
    check("seq_c", imem_addr_F, 64'hC);

    // Taken branch for one edge, then sequential.
    PCSrc_F    = 1'b1;
    PCBranch_F = 64'h100;
    step();
    check("branch_100", imem_addr_F, 64'h100);
    PCSrc_F = 1'b0;
    step();
    check("seq_104", imem_addr_F, 64'h104);
    step();
    check("seq_108", imem_addr_F, 64'h108);

    // Mid-cycle reset with a branch pending: forced to 0 before the next edge, inputs ignored.
    #3;
    PCSrc_F    = 1'b1;
    PCBranch_F = 64'hABC;
    reset      = 1'b0;
    #1;
    check("reset_mid", imem_addr_F, 64'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("reset_ign_br%0d", i), imem_addr_F, 64'h0);
    end

    // First edge after release loads the branch target.
    #2;
    reset = 1'b1;
    #1;
    check("release_hold2", imem_addr_F, 64'h0);
    step();
    check("post_rst_br", imem_addr_F, 64'hABC);
    PCSrc_F = 1'b0;
    step();
    check("seq_ac0", imem_addr_F, 64'hAC0);

    // Mid-cycle reset discarding an increment; first edge after release loads 0x4.
    #3;
    reset = 1'b0;
    #1;
    check("reset_mid2", imem_addr_F, 64'h0);
    step();
    check("reset_hold2", imem_addr_F, 64'h0);
    #2;
    reset = 1'b1;
    step();
    check("post_rst_seq", imem_addr_F, 64'h4);

    // Wrap at the top of the address space.
    PCSrc_F    = 1'b1;
    PCBranch_F = 64'hFFFF_FFFF_FFFF_FFFC;
    step();
    check("branch_top", imem_addr_F, 64'hFFFF_FFFF_FFFF_FFFC);
    PCSrc_F = 1'b0;
    step();
    check("wrap_0", imem_addr_F, 64'h0);
    step();
    check("wrap_4", imem_addr_F, 64'h4);

    // Unaligned target accepted unmodified.
    PCSrc_F    = 1'b1;
    PCBranch_F = 64'h3;
    step();
    check("branch_unal", imem_addr_F, 64'h3);
    PCSrc_F = 1'b0;
    step();
    check("unal_7", imem_addr_F, 64'h7);
    step();
    check("unal_b", imem_addr_F, 64'hB);

    // Branch to a high pattern exercises upper bits of the mux and register.
    PCSrc_F    = 1'b1;
    PCBranch_F = 64'h8000_0000_1234_5678;
    step();
    check("branch_hi", imem_addr_F, 64'h8000_0000_1234_5678);
    PCSrc_F = 1'b0;
    step();
    check("seq_hi", imem_addr_F, 64'h8000_0000_1234_567C);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end
endmodule
